// File: rtl/fpmul_sched_pkg.sv
// fpmul_sched_pkg: shared state encoding, iteration limits and Booth decode for the FP multiplier scheduler
package fpmul_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        TEST,
        ADD,
        SUB,
        SHIFT,
        NORM,
        PACK,
        RESP
    } state_t;

    localparam int CNT_W = 5;
    localparam int NCNT_W = 6;
    localparam logic [CNT_W-1:0] BOOTH_ITER = 5'd23;
    localparam logic [NCNT_W-1:0] NORM_MAX = 6'd46;

    function automatic state_t booth_next(input logic q0, input logic qm1);
        return ({q0, qm1} == 2'b10) ? SUB : ({q0, qm1} == 2'b01) ? ADD : SHIFT;
    endfunction

endpackage

// File: rtl/fpmul_rr_arb.sv
// fpmul_rr_arb: two-requester round-robin arbiter with registered one-cycle grant pulse and held operand select
module fpmul_rr_arb (
    input  logic       clock,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       sel_o
);

    logic       last_q, last_d;
    logic       sel_q, sel_d;
    logic [1:0] gnt_q, gnt_d;
    logic       pick;

    // on a tie favour the requester that did not win last time
    always_comb begin
        pick   = (req_i == 2'b11) ? ~last_q : req_i[1];
        gnt_d  = (en_i && |req_i) ? (pick ? 2'b10 : 2'b01) : 2'b00;
        last_d = |gnt_d ? pick : last_q;
        sel_d  = |gnt_d ? pick : sel_q;
    end

    // last winner starts at req1 so req0 takes the first tie; select holds until the next grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
            sel_q  <= 1'b0;
            gnt_q  <= 2'b00;
        end else begin
            last_q <= last_d;
            sel_q  <= sel_d;
            gnt_q  <= gnt_d;
        end
    end

    assign gnt_o = gnt_q;
    assign sel_o = sel_q;

endmodule

// File: rtl/fpmul_sched.sv
// fpmul_sched: Booth multiply / normalize / pack sequencer for a shared FP multiplier; FPMUL_SCHED_ZERO_BYPASS_EN enables zero-operand bypass
module fpmul_sched
    import fpmul_sched_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic req0_ready,
    output logic req1_ready,
    output logic op_sel,
    output logic dp_clear,
    output logic dp_brload,
    output logic dp_loadqr,
    output logic dp_loadac,
    output logic dp_add_sel,
    output logic dp_shift,
    output logic dp_norm_shift,
    output logic dp_pack,
    output logic dp_force_zero,
    input  logic dp_q0,
    input  logic dp_qm1,
    input  logic dp_msb,
    input  logic dp_zero,
    input  logic dp_opzero,
    output logic resp_valid,
    output logic resp_id,
    input  logic resp_ready
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NCNT_W-1:0]   ncnt_q, ncnt_d;
    logic [1:0]          gnt;
    logic                norm_go;
    logic                byp;

    fpmul_rr_arb u_arb (
        .clock (clock),
        .reset (reset),
        .en_i  (state_q == IDLE),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt),
        .sel_o (op_sel)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign norm_go    = !dp_msb && !dp_zero && (ncnt_q < NORM_MAX);

`ifdef FPMUL_SCHED_ZERO_BYPASS_EN
    logic fz_q, fz_d;
    assign byp           = dp_opzero && (cnt_q == BOOTH_ITER);
    assign dp_force_zero = (state_q == PACK) && fz_q;

    // remember that this operation skipped the Booth phase so PACK emits a zero result
    always_comb fz_d = (state_q == LOAD) ? 1'b0 : (state_q == TEST && byp) ? 1'b1 : fz_q;

    // bypass flag register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) fz_q <= 1'b0;
        else       fz_q <= fz_d;
    end
`else
    logic unused_opzero;
    assign byp           = 1'b0;
    assign dp_force_zero = 1'b0;
    assign unused_opzero = dp_opzero;
`endif

    // next state, counters and Moore datapath controls
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ncnt_d        = ncnt_q;
        dp_clear      = 1'b0;
        dp_brload     = 1'b0;
        dp_loadqr     = 1'b0;
        dp_loadac     = 1'b0;
        dp_add_sel    = 1'b0;
        dp_shift      = 1'b0;
        dp_norm_shift = 1'b0;
        dp_pack       = 1'b0;
        resp_valid    = 1'b0;
        resp_id       = 1'b0;
        case (state_q)
            IDLE: state_d = (req0_valid || req1_valid) ? LOAD : IDLE;
            LOAD: begin
                dp_clear  = 1'b1;
                dp_brload = 1'b1;
                dp_loadqr = 1'b1;
                cnt_d     = BOOTH_ITER;
                ncnt_d    = '0;
                state_d   = TEST;
            end
            TEST: state_d = byp ? PACK : booth_next(dp_q0, dp_qm1);
            ADD: begin
                dp_loadac = 1'b1;
                state_d   = SHIFT;
            end
            SUB: begin
                dp_loadac  = 1'b1;
                dp_add_sel = 1'b1;
                state_d    = SHIFT;
            end
            SHIFT: begin
                dp_shift = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                state_d  = (cnt_q == CNT_W'(1)) ? NORM : TEST;
            end
            NORM: begin
                dp_norm_shift = norm_go;
                ncnt_d        = norm_go ? ncnt_q + NCNT_W'(1) : ncnt_q;
                state_d       = norm_go ? NORM : PACK;
            end
            PACK: begin
                dp_pack = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_id    = op_sel;
                state_d    = resp_ready ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and counter registers; reset abandons any operation in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ncnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ncnt_q  <= ncnt_d;
        end
    end

endmodule

// File: tb/tb_fpmul_sched.sv
// tb_fpmul_sched: scoreboard bench for fpmul_sched with a behavioural Booth/normalizer datapath model
module tb_fpmul_sched;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0, dp_opzero = 1'b0;
    logic req0_ready, req1_ready, op_sel;
    logic dp_clear, dp_brload, dp_loadqr, dp_loadac, dp_add_sel, dp_shift, dp_norm_shift, dp_pack, dp_force_zero;
    logic dp_q0, dp_qm1, dp_msb, dp_zero;
    logic resp_valid, resp_id;
    logic [13:0] outs;

    typedef struct {
        int id;
        int lat;
        int sub;
        int add;
        int shf;
        int nsh;
        int fz;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0, n_fail = 0;
    int q_mode = 0, n_mode = 0;
    int sh_dp = 0, ns_dp = 0;
    int cyc = 0, g = 0, c_sub = 0, c_add = 0, c_shf = 0, c_nsh = 0, c_fz = 0;
    logic rv_prev = 1'b0;

    fpmul_sched dut (
        .clock         (clock),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req1_valid    (req1_valid),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .op_sel        (op_sel),
        .dp_clear      (dp_clear),
        .dp_brload     (dp_brload),
        .dp_loadqr     (dp_loadqr),
        .dp_loadac     (dp_loadac),
        .dp_add_sel    (dp_add_sel),
        .dp_shift      (dp_shift),
        .dp_norm_shift (dp_norm_shift),
        .dp_pack       (dp_pack),
        .dp_force_zero (dp_force_zero),
        .dp_q0         (dp_q0),
        .dp_qm1        (dp_qm1),
        .dp_msb        (dp_msb),
        .dp_zero       (dp_zero),
        .dp_opzero     (dp_opzero),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_ready    (resp_ready)
    );

    assign outs = {req0_ready, req1_ready, op_sel, dp_clear, dp_brload, dp_loadqr, dp_loadac,
                   dp_add_sel, dp_shift, dp_norm_shift, dp_pack, dp_force_zero, resp_valid, resp_id};

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // datapath model: shifter and normalizer advance on the clock edge when commanded
    always @(posedge clock) begin
        if (dp_clear) begin
            sh_dp <= 0;
            ns_dp <= 0;
        end else begin
            if (dp_shift) sh_dp <= sh_dp + 1;
            if (dp_norm_shift) ns_dp <= ns_dp + 1;
        end
    end

    always_comb begin
        {dp_q0, dp_qm1} = (q_mode == 1) ? 2'b10 : (q_mode == 2) ? 2'b01 : (q_mode == 3) ? 2'b11 :
                          (q_mode == 4) ? ((sh_dp == 0) ? 2'b10 : 2'b00) : 2'b00;
        dp_msb  = (n_mode == 0) || (n_mode == 2 && ns_dp >= 5);
        dp_zero = (n_mode == 3);
    end

    // monitor: counts control pulses since grant and scores each response against the queue
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (req0_ready || req1_ready) begin
            g = cyc;
            c_sub = 0; c_add = 0; c_shf = 0; c_nsh = 0; c_fz = 0;
        end
        if (dp_loadac && dp_add_sel) c_sub++;
        if (dp_loadac && !dp_add_sel) c_add++;
        if (dp_shift) c_shf++;
        if (dp_norm_shift) c_nsh++;
        if (dp_force_zero) c_fz++;
        chk("one_hot_ctrl", ($countones({dp_loadac, dp_shift, dp_norm_shift, dp_pack}) <= 1) ? 1 : 0, 1);
        if (resp_valid && !rv_prev) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("resp_id", int'(resp_id), e.id);
                chk("latency", cyc - g, e.lat);
                chk("sub_cnt", c_sub, e.sub);
                chk("add_cnt", c_add, e.add);
                chk("shift_cnt", c_shf, e.shf);
                chk("norm_cnt", c_nsh, e.nsh);
                chk("force_zero", c_fz, e.fz);
            end
        end
        rv_prev = resp_valid;
    end

    task automatic do_op(input bit r0, input bit r1, input int id, input int qm, input int nm, input bit oz,
                         input int lat, input int sub, input int add, input int shf, input int nsh, input int fz,
                         input int hold);
        exp_t e;
        bit got;
        e.id = id; e.lat = lat; e.sub = sub; e.add = add; e.shf = shf; e.nsh = nsh; e.fz = fz;
        sbq.push_back(e);
        q_mode = qm;
        n_mode = nm;
        dp_opzero = oz;
        req0_valid = r0;
        req1_valid = r1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = req0_ready | req1_ready;
        end
        chk("grant_seen", int'(got), 1);
        if (got) begin
            chk("grant_id", int'({req1_ready, req0_ready}), id ? 2 : 1);
            chk("op_sel", int'(op_sel), id);
            if (req1_ready) req1_valid = 1'b0;
            else req0_valid = 1'b0;
            got = 0;
            for (int i = 0; i < 300 && !got; i++) begin
                @(negedge clock);
                got = resp_valid;
            end
            chk("resp_seen", int'(got), 1);
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                chk("resp_hold", int'({resp_valid, resp_id, req0_ready, req1_ready}), 8 + 4 * id);
            end
            resp_ready = 1'b1;
            @(negedge clock);
            resp_ready = 1'b0;
            chk("resp_drop", int'(resp_valid), 0);
        end else begin
            void'(sbq.pop_back());
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        dp_opzero = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clock);
        chk("reset_outs", int'(outs), 0);
        reset = 1'b0;
        @(negedge clock);
        // tie after reset goes to req0; req1 waits through a 10-cycle stall
        do_op(1, 1, 0, 0, 0, 0, 49, 0, 0, 23, 0, 0, 10);
        do_op(1, 1, 1, 1, 0, 0, 72, 23, 0, 23, 0, 0, 0);
        do_op(1, 1, 0, 2, 0, 0, 72, 0, 23, 23, 0, 0, 3);
        do_op(0, 1, 1, 3, 1, 0, 95, 0, 0, 23, 46, 0, 0);
        do_op(1, 0, 0, 4, 2, 0, 55, 1, 0, 23, 5, 0, 0);
        do_op(0, 1, 1, 0, 3, 0, 49, 0, 0, 23, 0, 0, 0);
`ifdef FPMUL_SCHED_ZERO_BYPASS_EN
        do_op(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0);
`else
        do_op(1, 0, 0, 0, 0, 1, 49, 0, 0, 23, 0, 0, 0);
`endif
        // reset in the 20th Booth cycle of a req0 operation
        q_mode = 0;
        n_mode = 0;
        req0_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = req0_ready;
        end
        chk("midop_grant", int'(seen), 1);
        req0_valid = 1'b0;
        repeat (20) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk("midop_reset_outs", int'(outs), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            seen = seen | resp_valid;
        end
        chk("midop_no_resp", int'(seen), 0);
        // reset restored last-grant, so the next tie goes to req0 again
        do_op(1, 1, 0, 0, 0, 0, 49, 0, 0, 23, 0, 0, 0);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
